dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RISC-V core's load/store port: the memory-side end of the data access interface that the core's datapath drives with an address, store data and access size. It accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait states, and performs byte/halfword/word accesses with lane steering and sign/zero extension. It returns read data or a write acknowledge over a second valid/ready handshake. It replaces the zero-latency combinational data memory so that the multicycle and pipelined cores can be verified against realistic memory latency.

## Interface
Parameters:
- DEPTH, 256: memory size in 32-bit words; power of two, ≥ 4.
- WAIT, 2: wait states between accept and access; 0..15 legal.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  request was rejected (see Configuration).

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid is high on a clock edge, the request is accepted. addr, wdata, size, we and unsigned are latched, cnt ← WAIT, and the FSM moves to ACCESS.
- ACCESS:
  - req_ready = 0.
  - If cnt ≠ 0, cnt decrements.
  - If cnt = 0 on an edge, the access is performed and the FSM moves to RESP:
    - The store writes the selected byte lanes.
    - The load result is registered into rsp_rdata.
- RESP:
  - rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable until rsp_ready is sampled high.
  - When rsp_ready is sampled high, the FSM returns to IDLE.
  - A new request can be accepted on the edge after that.
- Word index is req_addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH·4 bytes.
- Byte lanes:
  - Byte accesses use lane addr[1:0].
  - Half accesses use lanes {addr[1],0} and {addr[1],1}.
  - Word accesses use all four lanes.
  - Store data is replicated into the selected lane(s). Unselected lanes are unchanged.
- Load extension:
  - Byte/half results are extended to 32 bits using bit 7 or bit 15 when req_unsigned = 0, and zero-extended otherwise.
  - Word loads are passed through unchanged.
- Store response: rsp_rdata = 0, rsp_err = 0.
- req_size = 11 is always an error: no write occurs, rsp_rdata = 0, rsp_err = 1.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, cnt 0.
- req_ready is combinational from state, and is forced to 0 while reset = 1.
- Latency: if the request is accepted at edge t0, rsp_valid is first high in the cycle after edge t0+WAIT+1.
- Minimum transaction period is WAIT+3 cycles (rsp_ready held high).
- Reset asserted mid-transaction:
  - The transaction is abandoned and no response is issued.
  - A store is not performed unless its access edge already occurred.
- req_valid may toggle freely while req_ready = 0; it is ignored.
- rsp_ready is ignored outside RESP.

## Configuration
- DMEM_ERR_EN defined:
  - Misaligned half (addr[0] = 1) and misaligned word (addr[1:0] ≠ 0) accesses are rejected with rsp_err = 1.
  - A rejected access causes no write and returns rsp_rdata = 0.
  - Latency is unchanged.
- DMEM_ERR_EN undefined:
  - Misaligned addresses are force-aligned: half uses addr[1], word ignores addr[1:0].
  - rsp_err is 1 only for req_size = 11.

## Structure
- Package dmem_pkg contains:
  - size encodings SIZE_B / SIZE_H / SIZE_W;
  - the FSM state enum;
  - the WAIT counter width constant (4).
- Sub-module dmem_lane_align is combinational. It produces:
  - the byte-enable mask;
  - replicated write data;
  - extended read data from {size, unsigned, addr[1:0], raw word}.
- Storage is an inferred reg array of DEPTH×32 with per-byte write enables.

## Test plan
- WAIT = 2, store word 0xDEADBEEF at 0x10, then load word 0x10:
  - rsp_rdata = 0xDEADBEEF;
  - rsp_valid first high 3 cycles after accept.
- Store byte 0x80 at 0x13, then load byte signed 0x13 and unsigned 0x13:
  - results are 0xFFFFFF80 and 0x00000080;
  - load word 0x10 returns 0x80ADBEEF.
- Back-pressure: hold rsp_ready = 0 for 5 cycles in RESP:
  - rsp_valid, rsp_rdata and rsp_err stay constant;
  - req_ready stays 0;
  - IDLE is entered one edge after rsp_ready = 1.
- Load half at 0x11:
  - with DMEM_ERR_EN, rsp_err = 1 and rsp_rdata = 0;
  - without it, the result is the half at 0x10.
- Address 0x400 with DEPTH = 256 aliases 0x000: store to 0x400, read from 0x000, and the values match.
- Assert reset during ACCESS of a store:
  - no rsp_valid is issued;
  - the target word is unchanged;
  - req_ready = 1 on the cycle after reset deasserts.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states and wait-counter width.
// The optional DMEM_ERR_EN build also uses the misalignment helper below.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dmem_state_e;

    // A half must sit on an even byte, a word on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_H:  mis = addr_lo[0];
            SIZE_W:  mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for writes,
// and selection plus sign/zero extension of the raw word for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned halves and words are force-aligned here simply by ignoring the low bits.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (size)
            SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SIZE_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel  = rdata_raw[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
        rdata_ext = '0;
        case (size)
            SIZE_B:  rdata_ext = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SIZE_H:  rdata_ext = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            SIZE_W:  rdata_ext = rdata_raw;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with WAIT wait states, valid/ready request and response handshakes.
// Define DMEM_ERR_EN to reject misaligned half/word accesses instead of force-aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_e       state;
    dmem_state_e       state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              do_access;

    logic              lat_we;
    logic [IDX_W-1:0]  lat_idx;
    logic [1:0]        lat_lo;
    logic [1:0]        lat_size;
    logic              lat_uns;
    logic [31:0]       lat_wdata;

    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       rdata_raw;
    logic [31:0]       rdata_ext;
    logic              req_err;

    logic [31:0]       mem [DEPTH];

    // Address bits above the word index are deliberately dropped so accesses wrap.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_valid)    state_nxt = ST_ACCESS;
            ST_ACCESS: if (cnt == '0)    state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready)    state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // The access is suppressed on a reset edge so an abandoned store never lands.
    always_comb begin
        req_ready = (state == ST_IDLE) && !reset;
        rsp_valid = (state == ST_RESP);
        accept    = req_ready && req_valid;
        do_access = (state == ST_ACCESS) && (cnt == '0) && !reset;
    end

`ifdef DMEM_ERR_EN
    assign req_err = (lat_size == SIZE_R) || is_misaligned(lat_size, lat_lo);
`else
    assign req_err = (lat_size == SIZE_R);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_lo    <= 2'b00;
            lat_size  <= SIZE_B;
            lat_uns   <= 1'b0;
            lat_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_idx   <= req_addr[IDX_W+1:2];
                lat_lo    <= req_addr[1:0];
                lat_size  <= req_size;
                lat_uns   <= req_unsigned;
                lat_wdata <= req_wdata;
                cnt       <= CNT_W'(WAIT);
            end else if ((state == ST_ACCESS) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (do_access) begin
                rsp_rdata <= (lat_we || req_err) ? '0 : rdata_ext;
                rsp_err   <= req_err;
            end
        end
    end

    dmem_lane_align u_align (
        .size        (lat_size),
        .is_unsigned (lat_uns),
        .addr_lo     (lat_lo),
        .wdata       (lat_wdata),
        .rdata_raw   (rdata_raw),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .rdata_ext   (rdata_ext)
    );

    assign rdata_raw = mem[lat_idx];

    // Storage has no reset; only the enabled byte lanes of a non-rejected store are written.
    always_ff @(posedge clk) begin
        if (do_access && lat_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[lat_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-array memory model predicts each response,
// which is queued at request time and compared when the responder answers.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WAIT  = 2;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } sb_t;

    sb_t         exp_q[$];
    logic [7:0]  ref_mem [0:NBYTES-1];
    int          n_compared = 0;
    int          n_mismatched = 0;

    dmem_responder #(.DEPTH(DEPTH), .WAIT(WAIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic modelErr(input logic [31:0] addr, input logic [1:0] size);
        logic e;
        e = (size == 2'b11);
`ifdef DMEM_ERR_EN
        if (size == 2'b01 && addr[0]) e = 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic int alignedBase(input logic [31:0] addr, input logic [1:0] size);
        int a;
        a = int'(addr % NBYTES);
        if (size == 2'b01) a = a - (a % 2);
        if (size == 2'b10) a = a - (a % 4);
        return a;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        int a;
        logic [31:0] v;
        a = alignedBase(addr, size);
        v = '0;
        case (size)
            2'b00: v = uns ? {24'h0, ref_mem[a]} : {{24{ref_mem[a][7]}}, ref_mem[a]};
            2'b01: v = uns ? {16'h0, ref_mem[a+1], ref_mem[a]}
                           : {{16{ref_mem[a+1][7]}}, ref_mem[a+1], ref_mem[a]};
            2'b10: v = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic modelStore(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
        int a;
        a = alignedBase(addr, size);
        case (size)
            2'b00: ref_mem[a] = wdata[7:0];
            2'b01: begin
                ref_mem[a]   = wdata[7:0];
                ref_mem[a+1] = wdata[15:8];
            end
            2'b10: begin
                ref_mem[a]   = wdata[7:0];
                ref_mem[a+1] = wdata[15:8];
                ref_mem[a+2] = wdata[23:16];
                ref_mem[a+3] = wdata[31:24];
            end
            default: ;
        endcase
    endtask

    // Drives one request, leaving the bench 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic uns);
        sb_t e;
        int  n;
        e.we        = we;
        e.addr      = addr;
        e.wdata     = wdata;
        e.size      = size;
        e.exp_err   = modelErr(addr, size);
        e.exp_rdata = (we || e.exp_err) ? 32'h0 : modelLoad(addr, size, uns);
        exp_q.push_back(e);
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("req_ready_before_accept", req_ready, 1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("accept_ready_drops", req_ready, 0);
    endtask

    task automatic collectResponse(input int hold);
        sb_t e;
        int  lat;
        lat = 0;
        while (!rsp_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, WAIT + 1);
        checkOutput("sb_depth", exp_q.size(), 1);
        e = exp_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            checkOutput("rsp_valid", rsp_valid, 1);
            checkOutput("rsp_rdata", rsp_rdata, e.exp_rdata);
            checkOutput("rsp_err", rsp_err, e.exp_err);
            checkOutput("busy_req_ready", req_ready, 0);
            if (i < hold) begin
                req_valid = (i % 2 == 0);
                req_we    = 1'b1;
                req_addr  = e.addr;
                req_wdata = 32'h5555AAAA;
                req_size  = 2'b10;
                @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput("back_to_idle_ready", req_ready, 1);
        checkOutput("back_to_idle_valid", rsp_valid, 0);
        if (e.we && !e.exp_err) modelStore(e.addr, e.wdata, e.size);
    endtask

    task automatic doAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic uns, input int hold);
        applyStimulus(we, addr, wdata, size, uns);
        collectResponse(hold);
    endtask

    initial begin
        $display("[TB] starting dmem_responder bench, WAIT=%0d DEPTH=%0d", WAIT, DEPTH);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_req_ready", req_ready, 0);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_ready", req_ready, 1);

        // Word store/load, then byte lanes with sign and zero extension.
        doAccess(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0);
        doAccess(1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 0);
        doAccess(1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, 0);
        doAccess(1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 0);
        doAccess(1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 0);
        doAccess(1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 5);
        doAccess(1'b0, 32'h11, 32'h0,        2'b01, 1'b0, 0);
        doAccess(1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 0);

        // Reserved size never writes and always errors.
        doAccess(1'b1, 32'h30, 32'h11223344, 2'b10, 1'b0, 0);
        doAccess(1'b1, 32'h30, 32'hFFFFFFFF, 2'b11, 1'b0, 1);
        doAccess(1'b0, 32'h30, 32'h0,        2'b11, 1'b0, 0);
        doAccess(1'b0, 32'h30, 32'h0,        2'b10, 1'b0, 0);

        // Aliasing: 0x400 wraps onto 0x000.
        doAccess(1'b1, 32'h400, 32'hA5A55A5A, 2'b10, 1'b0, 0);
        doAccess(1'b0, 32'h000, 32'h0,        2'b10, 1'b0, 0);
        doAccess(1'b1, 32'hFFFF_F3FE, 32'h0000C3D2, 2'b01, 1'b0, 0);
        doAccess(1'b0, 32'h3FC, 32'h0,        2'b10, 1'b0, 2);

        // Reset during the wait states of a store abandons it.
        doAccess(1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, 0);
        applyStimulus(1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_req_ready_in_reset", req_ready, 0);
        checkOutput("abort_rsp_valid_in_reset", rsp_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete(0);
        #1;
        checkOutput("abort_ready_after_reset", req_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_response", rsp_valid, 0);
        end
        doAccess(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0);

        // Mixed random traffic over a small initialised window.
        for (int w = 0; w < 4; w++) begin
            doAccess(1'b1, 32'h40 + 32'(4*w), $urandom, 2'b10, 1'b0, 0);
        end
        for (int k = 0; k < 16; k++) begin
            doAccess(1'($urandom_range(0, 1)), 32'h40 + 32'($urandom_range(0, 15)), $urandom,
                     2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
